alu_seq_nbit: RTL and testbench

- Registered, handshaked successor to the combinational N-bit ALU.
- Keeps the existing opcode map: ADD, SUB, AND, OR, XOR.
- Adds logical shifts, an iterative N-cycle unsigned multiply, a signed-overflow flag and an illegal-opcode flag.
- Sits between an operand source and a result sink, with valid/ready on both sides. Single-cycle ops sustain one result per cycle.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_mul_iter.sv | 58 +++++
 rtl/alu_seq_nbit.sv | 153 +++++++++++++++
 tb/tb_alu_seq_nbit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM encoding, flag bundle and overflow helper for the sequential ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_seq_pkg;

  // Opcode map; the ADD..XOR codes match the older combinational ALU.
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_MUL = 4'h7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Status flags carried alongside every result.
  typedef struct packed {
    logic zero;
    logic cout;
    logic borrow;
    logic ovf;
    logic err;
  } flags_t;

  // Two's-complement overflow from the operand and result sign bits.
  // For a subtract, B's sign is inverted because A-B is A+(-B).
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    logic b_eff;
    b_eff = is_sub ? ~b_msb : b_msb;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned N x N multiplier with start/done strobes.
// Latency: done pulses N edges after the start edge; prod is valid while done is high.
// Backpressure: none; the caller starts it only when it can take the result.
module alu_mul_iter #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             done,
  output logic [2*N-1:0]   prod
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]   a_q;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_nxt;
  logic [N:0]     psum;
  logic [CW-1:0]  cnt;
  logic           busy;

  // One step: add the multiplicand into the high half if the current multiplier
  // bit (acc LSB) is set, then shift the whole accumulator right by one.
  always_comb begin
    psum    = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? a_q : {N{1'b0}})};
    acc_nxt = {psum, acc[N-1:1]};
  end

  // The final step's sum is handed out combinationally so the caller can
  // register it on the same edge the counter reaches zero.
  assign done = busy && (cnt == CW'(1));
  assign prod = acc_nxt;

  // Operand latch, accumulator and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_q  <= a;
      acc  <= {{N{1'b0}}, b};
      cnt  <= CW'(N);
      busy <= 1'b1;
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with valid/ready on both sides and an iterative multiply.
// Latency: 1 edge for single-cycle ops, N edges for MUL; one result per cycle when streaming.
// Backpressure: a held result (out_valid && !out_ready) freezes outputs and drops in_ready.
module alu_seq_nbit
  import alu_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   Sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic [N-1:0] Y_hi,
  output logic         Zero,
  output logic         Cout,
  output logic         Borrow,
  output logic         Ovf,
  output logic         Err
);

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic           mul_start;
  logic           mul_done;
  logic           mul_fin;
  logic [2*N-1:0] mul_prod;
  flags_t         mul_f;

  logic [SW-1:0]  sh;
  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [N:0]     shl_w;
  logic [N:0]     shr_w;
  logic [N-1:0]   sc_y;
  flags_t         sc_f;
  flags_t         flg;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (Sel == OP_MUL);
  assign mul_fin   = (state == ST_MUL) && mul_done;

  assign {Zero, Cout, Borrow, Ovf, Err} = flg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave IDLE on a MUL accept, return when the multiplier finishes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ready only when idle and the output slot is empty or being drained this cycle.
  always_comb begin
    in_ready = (state == ST_IDLE) && (!out_valid || out_ready) && !rst;
  end

  alu_mul_iter #(.N(N)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (A),
    .b     (B),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Multiply flags: only Zero is meaningful, and it covers the full product.
  always_comb begin
    mul_f      = '0;
    mul_f.zero = (mul_prod == '0);
  end

  // Single-cycle datapath. Shifts use one guard bit so the last bit shifted out
  // lands in a fixed position; a zero shift leaves the guard bit clear.
  always_comb begin
    sh    = B[SW-1:0];
    sum   = {1'b0, A} + {1'b0, B};
    diff  = {1'b0, A} - {1'b0, B};
    shl_w = {1'b0, A} << sh;
    shr_w = {A, 1'b0} >> sh;
    sc_y  = '0;
    sc_f  = '0;
    case (Sel)
      OP_ADD: begin
        sc_y     = sum[N-1:0];
        sc_f.cout = sum[N];
        sc_f.ovf  = signed_ovf(A[N-1], B[N-1], sum[N-1], 1'b0);
      end
      OP_SUB: begin
        sc_y        = diff[N-1:0];
        sc_f.borrow = diff[N];
        sc_f.ovf    = signed_ovf(A[N-1], B[N-1], diff[N-1], 1'b1);
      end
      OP_AND: sc_y = A & B;
      OP_OR:  sc_y = A | B;
      OP_XOR: sc_y = A ^ B;
      OP_SHL: begin
        sc_y      = shl_w[N-1:0];
        sc_f.cout = shl_w[N];
      end
      OP_SHR: begin
        sc_y      = shr_w[N:1];
        sc_f.cout = shr_w[0];
      end
      OP_MUL: sc_y = '0;
      default: sc_f.err = 1'b1;
    endcase
    sc_f.zero = (sc_y == '0);
  end

  // Result registers: load on a single-cycle accept or multiplier finish,
  // otherwise drop out_valid once the sink takes the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Y         <= '0;
      Y_hi      <= '0;
      flg       <= '0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      Y         <= sc_y;
      Y_hi      <= '0;
      flg       <= sc_f;
    end else if (mul_fin) begin
      out_valid <= 1'b1;
      Y         <= mul_prod[N-1:0];
      Y_hi      <= mul_prod[2*N-1:N];
      flg       <= mul_f;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Self-checking bench for alu_seq_nbit: directed plan plus randomized traffic.
// Latency: expected results carry the edge at which they must appear.
// Backpressure: random out_ready exercises hold, retire and retire-with-accept.
module tb_alu_seq_nbit;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [3:0]   Sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] Y;
  logic [N-1:0] Y_hi;
  logic         Zero;
  logic         Cout;
  logic         Borrow;
  logic         Ovf;
  logic         Err;

  typedef struct packed {
    logic [N-1:0] y;
    logic [N-1:0] yhi;
    logic         zero;
    logic         cout;
    logic         borrow;
    logic         ovf;
    logic         err;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  logic rst_edge = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_seq_nbit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .Y_hi      (Y_hi),
    .Zero      (Zero),
    .Cout      (Cout),
    .Borrow    (Borrow),
    .Ovf       (Ovf),
    .Err       (Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic res_t model(input int op, input int a, input int b);
    res_t r;
    int m, s, sa, sb, sh, p;
    r  = '0;
    m  = 1 << N;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sh = b % N;
    case (op)
      0: begin
        s = a + b;
        r.y = N'(s % m);
        r.cout = (s >= m);
        s = sa + sb;
        r.ovf = (s >= m / 2) || (s < -(m / 2));
      end
      1: begin
        r.y = N'((a - b + m) % m);
        r.borrow = (a < b);
        s = sa - sb;
        r.ovf = (s >= m / 2) || (s < -(m / 2));
      end
      2: r.y = N'(a & b);
      3: r.y = N'(a | b);
      4: r.y = N'(a ^ b);
      5: begin
        r.y = N'((a << sh) % m);
        r.cout = (sh != 0) && (((a >> (N - sh)) & 1) == 1);
      end
      6: begin
        r.y = N'(a >> sh);
        r.cout = (sh != 0) && (((a >> (sh - 1)) & 1) == 1);
      end
      7: begin
        p = a * b;
        r.y = N'(p % m);
        r.yhi = N'(p / m);
      end
      default: r.err = 1'b1;
    endcase
    r.zero = (r.y == '0) && (r.yhi == '0);
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_edge = rst;
  end

  // Monitor: checks valid, result and ready against the scoreboard each cycle.
  always @(negedge clk) begin : mon
    logic held;
    logic busy;
    ent_t e;
    if (rst) begin
      chk("rdy_in_rst", 64'(in_ready), 64'(0));
      if (rst_edge) begin
        chk("rst_outputs", 64'({out_valid, Y, Y_hi, Zero, Cout, Borrow, Ovf, Err}), 64'(0));
      end
      q.delete();
    end else begin
      held = (q.size() > 0) && (q[0].due <= cyc);
      busy = (q.size() > 0) && (q[q.size()-1].due > cyc);
      chk("out_valid", 64'(out_valid), 64'(held));
      if (held) begin
        chk("result", 64'({Y, Y_hi, Zero, Cout, Borrow, Ovf, Err}), 64'(q[0].r));
      end
      chk("in_ready", 64'(in_ready), 64'(!busy && (!held || out_ready)));
      if (held && out_ready) begin
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        e.r   = model(int'(Sel), int'(A), int'(B));
        e.due = cyc + ((Sel == 4'd7) ? 1 + N : 1);
        q.push_back(e);
      end
    end
  end

  // Present an operation and hold it until it is taken (bounded wait).
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    Sel = op;
    A = a;
    B = b;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    chk("accept_wait", 64'(ok), 64'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    A = N'($urandom);
    B = N'($urandom);
    Sel = 4'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Arithmetic
    issue(4'd0, 8'd15, 8'd10);
    issue(4'd0, 8'd200, 8'd100);
    issue(4'd1, 8'd20, 8'd25);
    issue(4'd1, 8'd5, 8'd5);
    issue(4'd1, 8'h80, 8'h01);
    idle(1);

    // Multiply, operands scrambled right after accept
    issue(4'd7, 8'd200, 8'd3);
    idle(10);
    issue(4'd7, 8'h00, 8'hFF);
    idle(10);

    // Back-to-back single-cycle ops
    issue(4'd2, 8'hF0, 8'h3C);
    issue(4'd3, 8'hF0, 8'h0F);
    issue(4'd4, 8'hAA, 8'hFF);
    issue(4'd5, 8'h81, 8'h01);
    issue(4'd6, 8'h81, 8'h01);
    idle(2);

    // Backpressure, then retire and accept on the same edge
    out_ready = 1'b0;
    issue(4'd0, 8'h7F, 8'h01);
    in_valid = 1'b1;
    Sel = 4'd4;
    A = 8'h5A;
    B = 8'h0F;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Reset during the 4th multiply cycle
    issue(4'd7, 8'hC3, 8'h5A);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    // Illegal opcode
    issue(4'hF, 8'h12, 8'h34);
    idle(2);

    // Random traffic with random sink stalls
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      Sel       = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      A         = N'($urandom);
      B         = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end

    out_ready = 1'b1;
    idle(20);
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
